mux_sel_arbiter: RTL

//  Upstream select generator for the team's 4:1 mux.

---
 rtl/mux_sel_arbiter_pkg.sv | 16 +
 rtl/mux_sel_arbiter_if.sv | 25 ++
 rtl/mux_sel_arbiter_rr_pick4.sv | 28 ++
 rtl/mux_sel_arbiter.sv | 84 ++++++++
 4 files changed

// File: rtl/mux_sel_arbiter_pkg.sv
// Shared constants, state encoding and select-to-grant helper for the mux select arbiter.
package mux_arb_pkg;
   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [SEL_W-1:0] LAST_RST = 2'd3;

   function automatic logic [N_REQ-1:0] sel2grant(input logic [SEL_W-1:0] s);
      return {{(N_REQ-1){1'b0}}, 1'b1} << s;
   endfunction
endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Requester/consumer bundle for the mux select arbiter; master is the arbiter side.
// The lock signal exists only when MUX_ARB_LOCK_EN is defined.
interface mux_sel_arbiter_if
   import mux_arb_pkg::*;
#(
   parameter int CNT_W = 8
);
   logic [N_REQ-1:0] req;
   logic             out_ready;
`ifdef MUX_ARB_LOCK_EN
   logic             lock;
`endif
   logic [SEL_W-1:0] sel;
   logic             sel_valid;
   logic [N_REQ-1:0] grant;
   logic [CNT_W-1:0] xfer_cnt;

`ifdef MUX_ARB_LOCK_EN
   modport master (input req, out_ready, lock, output sel, sel_valid, grant, xfer_cnt);
   modport slave  (output req, out_ready, lock, input sel, sel_valid, grant, xfer_cnt);
`else
   modport master (input req, out_ready, output sel, sel_valid, grant, xfer_cnt);
   modport slave  (output req, out_ready, input sel, sel_valid, grant, xfer_cnt);
`endif
endinterface

// File: rtl/mux_sel_arbiter_rr_pick4.sv
// Round-robin pick over 4 requests, searching from last+1 upward with wrap.
// Latency: combinational. Backpressure: none.
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] last,
   output logic [SEL_W-1:0] pick,
   output logic             any
);
   logic [SEL_W-1:0]   start;
   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic [SEL_W-1:0]   off;

   always_comb begin
      start = last + 2'd1;
      dbl   = {req, req};
      rot   = dbl[start +: N_REQ];
      off   = '0;
      // Descending scan so the lowest rotated index wins.
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (rot[j]) off = SEL_W'(j);
      end
      pick = start + off;
      any  = |req;
   end
endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin select generator for the 4:1 mux; optional owner lock via MUX_ARB_LOCK_EN.
// Latency: 1 cycle from req to sel_valid; back-to-back grants without bubble on transfer.
// Backpressure: sel/grant held while out_ready is low; req changes ignored during a stall.
module mux_sel_arbiter
   import mux_arb_pkg::*;
#(
   parameter int CNT_W = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   mux_sel_arbiter_if.master bus
);
   state_t           state;
   logic [SEL_W-1:0] last;
   logic [SEL_W-1:0] sel_q;
   logic             vld_q;
   logic [N_REQ-1:0] grant_q;
   logic [CNT_W-1:0] cnt_q;

   logic [SEL_W-1:0] arb_last;
   logic [SEL_W-1:0] pick;
   logic             any;
   logic             keep;

   // On a transfer the departing owner becomes the new round-robin origin.
   assign arb_last = (state == GRANT) ? sel_q : last;

`ifdef MUX_ARB_LOCK_EN
   assign keep = bus.lock & bus.req[sel_q];
`else
   assign keep = 1'b0;
`endif

   rr_pick4 u_pick (
      .req  (bus.req),
      .last (arb_last),
      .pick (pick),
      .any  (any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         last    <= LAST_RST;
         sel_q   <= '0;
         vld_q   <= 1'b0;
         grant_q <= '0;
         cnt_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  sel_q   <= pick;
                  grant_q <= sel2grant(pick);
                  vld_q   <= 1'b1;
                  state   <= GRANT;
               end
            end
            GRANT: begin
               if (bus.out_ready) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (!keep) begin
                     last <= sel_q;
                     if (any) begin
                        sel_q   <= pick;
                        grant_q <= sel2grant(pick);
                     end else begin
                        vld_q   <= 1'b0;
                        grant_q <= '0;
                        state   <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sel       = sel_q;
   assign bus.sel_valid = vld_q;
   assign bus.grant     = grant_q;
   assign bus.xfer_cnt  = cnt_q;
endmodule
